window5_gen: RTL and testbench
==============================

Name: window5_gen

Overview:
- Sliding 5-sample window generator. Sits directly upstream of the 5-tap 1D Gaussian stage.
- Converts a serial line of samples (one sample per accepted beat) into packed 5-sample windows, one window per input sample.
- Replicates edge samples at both line ends, so a line of N samples always yields exactly N windows.
- The downstream stage has no backpressure. This block stalls its own input only while flushing the tail of a line.

Parameters:
DATA_WIDTH, 14, bit width of one sample; matches the downstream filter's DATA_WIDTH.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input sample valid
in_value  input  DATA_WIDTH  input sample
in_last  input  1  qualifies the accepted sample as the final sample of the line
in_ready  output  1  block can accept a sample this cycle
out_window_valid  output  1  out_window_value holds a valid window this cycle
out_window_value  output  5*DATA_WIDTH  packed window; slot k = bits [k*DATA_WIDTH +: DATA_WIDTH]; slot 0 oldest (x-2), slot 2 centre, slot 4 newest (x+2)
out_window_last  output  1  window is the last of the line; only meaningful with out_window_valid

Behaviour:
- Storage: shift register s0..s4 drives out_window_value directly (s0 to slot 0). cnt: 2-bit saturating count of samples accepted in the current line (0..3).
- States: IDLE (no sample of current line yet), RUN, FLUSH1, FLUSH2.
- in_ready = 1 in IDLE and RUN, 0 in FLUSH1 and FLUSH2 (decoded from state only). Accept = in_valid & in_ready.
- Accept in IDLE:
  - s0..s4 <= in_value (left-edge replication); cnt <= 1.
  - No window emitted.
  - Next state RUN, or FLUSH1 if in_last.
- Accept in RUN:
  - Shift: s0<=s1, s1<=s2, s2<=s3, s3<=s4, s4<=in_value; cnt saturates at 3.
  - A window is emitted when the post-update cnt is 3, i.e. from the 3rd sample of the line onward.
  - in_last moves to FLUSH1.
- FLUSH1 (one cycle):
  - Shift with s4 <= s4 (right-edge replication). Always emits.
  - Next state FLUSH2 if cnt >= 2, else IDLE, with out_window_last = 1 on this window.
- FLUSH2 (one cycle):
  - Same shift. Emits with out_window_last = 1.
  - Next state IDLE.
- Entering IDLE clears cnt.
- Outputs are registered:
  - out_window_valid/out_window_last are set by the same clock edge that performs the emitting update. They are 1 for exactly one cycle per window.
  - Latency: the window centred on sample i appears the cycle after sample i+2 is accepted, or in the flush cycle that replaces it.
- Windows per line:
  - max(0, N-2) during RUN plus min(N, 2) in flush, which totals N for every N >= 1.
  - N = 1: a single all-x0 window is emitted from FLUSH1 with last = 1.
- No accept in a cycle: s0..s4 and cnt hold. out_window_valid = 0 and out_window_last = 0 unless a flush state is active. out_window_value keeps its old contents and is not zeroed.
- in_valid while in_ready = 0: the beat is not accepted. The upstream source holds it and it is accepted after return to IDLE.
- A new line may start in the cycle immediately after FLUSH2/FLUSH1 returns to IDLE. This gives 2 (or 1) bubble cycles between lines.
- Inter-sample gaps (in_valid low) inside a line are legal and do not alter the windows.
- Reset (asynchronous, any time including mid-line or mid-flush):
  - state IDLE, cnt 0, s0..s4 0.
  - out_window_valid 0, out_window_last 0, out_window_value 0.
  - in_ready 1 after reset. The partial line is discarded with no windows for it.
- No arithmetic is performed. Samples are passed through unmodified, so the full DATA_WIDTH is preserved.

Test Plan:
- Line 10,20,30,40,50 back-to-back, last on 50 -> 5 windows (slot0..slot4): [10,10,10,20,30], [10,10,20,30,40], [10,20,30,40,50], [20,30,40,50,50], [30,40,50,50,50]; last only on the 5th; in_ready low exactly 2 cycles after accepting 50.
- Single-sample line 7 with last -> one window [7,7,7,7,7], last = 1; in_ready low 1 cycle.
- Two-sample line 3,9 -> [3,3,3,9,9] then [3,3,9,9,9] (last); then a new line 1,2,3 offered continuously -> first sample accepted the cycle after FLUSH2, windows [1,1,1,2,3], [1,1,2,3,3], [1,2,3,3,3]; no data from the prior line leaks into them.
- Line 100,200,300,400 with in_valid low 3 cycles between every sample -> windows identical to the gap-free case; out_window_valid pulses 1 cycle each; value held between pulses.
- Assert rst_n low during FLUSH1 of line 5,6,7 -> all outputs 0 immediately (asynchronous); after release a line 8 gives a single [8,8,8,8,8] window.
- Max-value samples 16383 (DATA_WIDTH = 14) over a 6-sample line -> 6 windows, all slots 16383, no truncation.

Source files
------------

// File: rtl/window5_gen.sv
// Sliding 5-sample window generator with edge replication at both line ends.
// Feeds the 5-tap Gaussian stage: one registered window per input sample.
module window5_gen #(
  parameter int DATA_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_value,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_window_valid,
  output logic [5*DATA_WIDTH-1:0] out_window_value,
  output logic                    out_window_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  state_t                       state, state_nx;
  logic [1:0]                   cnt, cnt_nx;
  logic [4:0][DATA_WIDTH-1:0]   s;
  logic [DATA_WIDTH-1:0]        feed;
  logic                         accept, load, shift, emit, last_nx;

  assign in_ready         = (state == IDLE) || (state == RUN);
  assign accept           = in_valid && in_ready;
  assign out_window_value = s;
  // Flush cycles re-insert the newest sample to replicate the right edge.
  assign feed             = (state == RUN) ? in_value : s[4];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;
    last_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load     = 1'b1;
          cnt_nx   = 2'd1;
          state_nx = in_last ? FLUSH1 : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          shift  = 1'b1;
          cnt_nx = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
          emit   = (cnt >= 2'd2);
          if (in_last) state_nx = FLUSH1;
        end
      end
      FLUSH1: begin
        shift = 1'b1;
        emit  = 1'b1;
        if (cnt >= 2'd2) begin
          state_nx = FLUSH2;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 2'd0;
          last_nx  = 1'b1;
        end
      end
      FLUSH2: begin
        shift    = 1'b1;
        emit     = 1'b1;
        last_nx  = 1'b1;
        cnt_nx   = 2'd0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= 2'd0;
      s                <= '0;
      out_window_valid <= 1'b0;
      out_window_last  <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      out_window_valid <= emit;
      out_window_last  <= last_nx;
      if (load)       s <= {5{in_value}};
      else if (shift) s <= {feed, s[4:1]};
    end
  end

endmodule

// File: tb/tb_window5_gen.sv
// Bench for window5_gen: clamped-index line model checked every cycle,
// plus literal window lists for the directed lines.
module tb_window5_gen;
  localparam int W  = 14;
  localparam int WW = 5 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, in_ready;
  logic [W-1:0]  in_value;
  logic          out_window_valid, out_window_last;
  logic [WW-1:0] out_window_value;

  window5_gen #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .in_last(in_last), .in_ready(in_ready), .out_window_valid(out_window_valid),
    .out_window_value(out_window_value), .out_window_last(out_window_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state: samples of the current line, whether its last sample was seen,
  // and how many windows of it have appeared
  int            line[$];
  bit            ended = 1'b0;
  int            emitted = 0;
  int            ready_low = 0;
  logic [WW-1:0] cap_v[$];
  bit            cap_l[$];
  logic [WW-1:0] exp_v[$];
  bit            exp_l[$];
  logic [WW-1:0] prev_val;
  bit            prev_ok = 1'b0;
  bit            prev_acc = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mkwin(input int a, input int b, input int c, input int d, input int e);
    logic [4:0][W-1:0] t;
    t[0] = W'(a); t[1] = W'(b); t[2] = W'(c); t[3] = W'(d); t[4] = W'(e);
    return t;
  endfunction

  // window j of a line = samples j-2..j+2 with indices clamped to the line
  always @(negedge clk) begin
    if (!rst_n) begin
      line.delete();
      ended    = 1'b0;
      emitted  = 0;
      prev_ok  = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (!in_ready) ready_low++;
      if (out_window_valid) begin
        logic [4:0][W-1:0] e;
        bit missing;
        cap_v.push_back(out_window_value);
        cap_l.push_back(out_window_last);
        missing = (line.size() == 0) || (emitted >= line.size() && ended);
        e = '0;
        for (int k = 0; k < 5 && !missing; k++) begin
          int idx;
          idx = emitted - 2 + k;
          if (idx < 0) idx = 0;
          if (idx > line.size() - 1) begin
            if (ended) idx = line.size() - 1;
            else missing = 1'b1;
          end
          if (!missing) e[k] = W'(line[idx]);
        end
        if (missing) begin
          checks++;
          failures++;
          $display("FAIL early_window: got window %h, required none yet (line size %0d)",
                   out_window_value, line.size());
        end else begin
          chk("model_window", out_window_value, e);
          chk("model_last", WW'(out_window_last), WW'(ended && emitted == line.size() - 1));
        end
        emitted++;
      end else begin
        chk("last_without_valid", WW'(out_window_last), '0);
        if (prev_ok && !prev_acc) chk("value_hold", out_window_value, prev_val);
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) begin
        if (ended) begin
          if (emitted != line.size()) begin
            checks++;
            failures++;
            $display("FAIL accept_during_flush: got accept with %0d windows, required %0d first",
                     emitted, line.size());
          end
          line.delete();
          ended   = 1'b0;
          emitted = 0;
        end
        line.push_back(int'(in_value));
        if (in_last) ended = 1'b1;
      end
      prev_val = out_window_value;
      prev_ok  = 1'b1;
    end
  end

  task automatic send(input int v, input bit last, input int gap);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1; in_value = W'(v); in_last = last;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept for %0d, required accept within 20 cycles", v);
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_test();
    cap_v.delete(); cap_l.delete(); exp_v.delete(); exp_l.delete();
    ready_low = 0;
  endtask

  task automatic want(input logic [WW-1:0] v, input bit l);
    exp_v.push_back(v); exp_l.push_back(l);
  endtask

  task automatic check_cap(input string name);
    chk({name, "_count"}, WW'(cap_v.size()), WW'(exp_v.size()));
    for (int i = 0; i < exp_v.size() && i < cap_v.size(); i++) begin
      chk($sformatf("%s_win%0d", name, i), cap_v[i], exp_v[i]);
      chk($sformatf("%s_last%0d", name, i), WW'(cap_l[i]), WW'(exp_l[i]));
    end
    chk({name, "_line_complete"}, WW'(ended && emitted == line.size()), WW'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_value = '0;
    #2;
    chk("reset_valid", WW'(out_window_valid), '0);
    chk("reset_last",  WW'(out_window_last), '0);
    chk("reset_value", out_window_value, '0);
    chk("reset_ready", WW'(in_ready), WW'(1));
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // basic 5-sample line
    start_test();
    send(10, 0, 0); send(20, 0, 0); send(30, 0, 0); send(40, 0, 0); send(50, 1, 0);
    idle(5);
    want(mkwin(10, 10, 10, 20, 30), 0);
    want(mkwin(10, 10, 20, 30, 40), 0);
    want(mkwin(10, 20, 30, 40, 50), 0);
    want(mkwin(20, 30, 40, 50, 50), 0);
    want(mkwin(30, 40, 50, 50, 50), 1);
    check_cap("line5");
    chk("line5_ready_low", WW'(ready_low), WW'(2));

    // single-sample line
    start_test();
    send(7, 1, 0);
    idle(4);
    want(mkwin(7, 7, 7, 7, 7), 1);
    check_cap("line1");
    chk("line1_ready_low", WW'(ready_low), WW'(1));

    // two-sample line followed immediately by a new line
    start_test();
    send(3, 0, 0); send(9, 1, 0);
    send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
    idle(5);
    want(mkwin(3, 3, 3, 9, 9), 0);
    want(mkwin(3, 3, 9, 9, 9), 1);
    want(mkwin(1, 1, 1, 2, 3), 0);
    want(mkwin(1, 1, 2, 3, 3), 0);
    want(mkwin(1, 2, 3, 3, 3), 1);
    check_cap("line2_then3");
    chk("line2_then3_ready_low", WW'(ready_low), WW'(4));

    // gaps between samples
    start_test();
    send(100, 0, 3); send(200, 0, 3); send(300, 0, 3); send(400, 1, 3);
    idle(4);
    want(mkwin(100, 100, 100, 200, 300), 0);
    want(mkwin(100, 100, 200, 300, 400), 0);
    want(mkwin(100, 200, 300, 400, 400), 0);
    want(mkwin(200, 300, 400, 400, 400), 1);
    check_cap("gapped");

    // reset during FLUSH1
    send(5, 0, 0); send(6, 0, 0); send(7, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", WW'(out_window_valid), '0);
    chk("midreset_last",  WW'(out_window_last), '0);
    chk("midreset_value", out_window_value, '0);
    chk("midreset_ready", WW'(in_ready), WW'(1));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    start_test();
    send(8, 1, 0);
    idle(4);
    want(mkwin(8, 8, 8, 8, 8), 1);
    check_cap("after_reset");

    // full-scale samples
    start_test();
    for (int i = 0; i < 6; i++) send(16383, i == 5, 0);
    idle(5);
    for (int i = 0; i < 6; i++) want({WW{1'b1}}, i == 5);
    check_cap("maxval");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
